// File: rtl/math_acc_48.sv
// rtl/math_acc_48.sv - 48-bit frame accumulator with one partial sum per adder stage
// math_add_48 is the registered adder primitive; math_acc_48 is the top.
module math_add_48 #(
  parameter int USE_FABRIC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] a,
  input  logic [47:0] b,
  input  logic        in_valid,
  input  logic [1:0]  in_tag,
  output logic [48:0] sum,
  output logic        out_valid,
  output logic [1:0]  out_tag
);
  logic [48:0] s1;
  logic        v1;
  logic [1:0]  t1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      v1 <= 1'b0;
      t1 <= '0;
    end else begin
      s1 <= {1'b0, a} + {1'b0, b};
      v1 <= in_valid;
      t1 <= in_tag;
    end
  end

  generate
    if (USE_FABRIC != 0) begin : g_fabric
      assign sum       = s1;
      assign out_valid = v1;
      assign out_tag   = t1;
    end else begin : g_dsp
      logic [48:0] s2;
      logic        v2;
      logic [1:0]  t2;
      always_ff @(posedge clk) begin
        if (rst) begin
          s2 <= '0;
          v2 <= 1'b0;
          t2 <= '0;
        end else begin
          s2 <= s1;
          v2 <= v1;
          t2 <= t1;
        end
      end
      assign sum       = s2;
      assign out_valid = v2;
      assign out_tag   = t2;
    end
  endgenerate
endmodule

module math_acc_48 #(
  parameter int USE_FABRIC = 0,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 in_valid,
  input  logic [47:0]          in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [47:0]          out_sum,
  output logic                 out_carry
);
  localparam int LAT       = (USE_FABRIC != 0) ? 1 : 2;
  localparam int CAP_PHASE = (LAT == 2) ? 2 : 0;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, COMBINE, DONE} state_t;
  state_t state, state_next;

  logic [LEN_WIDTH-1:0] remaining;
  logic                 lane;
  logic [1:0]           phase;
  logic [47:0]          partial [2];
  logic                 carry_flag;
  logic [47:0]          sum_r;
  logic                 carry_r;

  logic        add_valid;
  logic [1:0]  add_tag;
  logic [47:0] add_a, add_b;
  logic [48:0] res;
  logic        res_valid;
  logic [1:0]  res_tag;
  logic        accept, capture;
  logic [47:0] fwd0, fwd1;

  assign accept  = (state == ACCUM) && in_valid;
  assign capture = (state == COMBINE) && (phase == CAP_PHASE[1:0]);

  // A lane's newest sum may still sit on the adder output, one cycle before it reaches partial.
  assign fwd0 = (res_valid && res_tag == 2'b00) ? res[47:0] : partial[0];
  assign fwd1 = (res_valid && res_tag == 2'b01) ? res[47:0] : partial[1];

  always_comb begin
    state_next = state;
    add_valid  = 1'b0;
    add_tag    = 2'b00;
    add_a      = fwd0;
    add_b      = in_data;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DONE : ACCUM;
      ACCUM: begin
        if (in_valid) begin
          add_valid = 1'b1;
          add_tag   = {1'b0, lane};
          add_a     = lane ? fwd1 : fwd0;
          if (remaining == LEN_WIDTH'(1)) state_next = DRAIN;
        end
      end
      DRAIN:   state_next = COMBINE;
      COMBINE: begin
        if (LAT == 2 && phase == 2'd0) begin
          add_valid = 1'b1;
          add_tag   = 2'b10;
          add_a     = fwd0;
          add_b     = fwd1;
        end
        if (capture) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      lane       <= 1'b0;
      phase      <= '0;
      partial[0] <= '0;
      partial[1] <= '0;
      carry_flag <= 1'b0;
      sum_r      <= '0;
      carry_r    <= 1'b0;
    end else begin
      state <= state_next;
      if (res_valid && !res_tag[1]) partial[res_tag[0]] <= res[47:0];
      if (res_valid) carry_flag <= carry_flag | res[48];
      if (state == IDLE && start) begin
        remaining  <= len;
        lane       <= 1'b0;
        partial[0] <= '0;
        partial[1] <= '0;
        carry_flag <= 1'b0;
        if (len == '0) begin
          sum_r   <= '0;
          carry_r <= 1'b0;
        end
      end
      if (accept) begin
        remaining <= remaining - LEN_WIDTH'(1);
        lane      <= (LAT == 2) ? ~lane : 1'b0;
      end
      phase <= (state == COMBINE) ? phase + 2'd1 : 2'd0;
      if (capture) begin
        if (LAT == 2) begin
          sum_r   <= res[47:0];
          carry_r <= carry_flag | res[48];
        end else begin
          sum_r   <= partial[0];
          carry_r <= carry_flag;
        end
      end
    end
  end

  math_add_48 #(.USE_FABRIC(USE_FABRIC)) u_add (
    .clk       (clk),
    .rst       (rst),
    .a         (add_a),
    .b         (add_b),
    .in_valid  (add_valid),
    .in_tag    (add_tag),
    .sum       (res),
    .out_valid (res_valid),
    .out_tag   (res_tag)
  );

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_r;
  assign out_carry = carry_r;
endmodule
